// File: rtl/tusca_serial_pkg.sv
// Shared definitions for the tusca serial receive path.
// Holds the state codes exposed on db_estado, the frame shape constants and
// the helper that turns a clock frequency and a line rate into clocks per bit.
package tusca_serial_pkg;

  // State codes as seen on db_estado. IDLE..STOP live in the byte receiver,
  // BYTE_DONE and WAIT_B1 belong to the word assembler.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    DATA      = 4'd2,
    PARITY    = 4'd3,
    STOP      = 4'd4,
    BYTE_DONE = 4'd5,
    WAIT_B1   = 4'd6
  } estado_t;

  // Phases of the word assembler. FASE_RX means the byte receiver owns the
  // line (idle or mid-frame); the other two map straight onto state codes.
  typedef enum logic [1:0] {
    FASE_RX,
    FASE_BYTE_DONE,
    FASE_WAIT_B1
  } fase_t;

  localparam int FRAME_DATA_BITS = 8;

  // A good frame has an odd number of ones across data plus parity.
  localparam bit PARIDADE_IMPAR = 1'b1;

  // Integer division on purpose: 50 MHz / 9600 gives 5208, / 115200 gives 434.
  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/rx_serial_8o1.sv
// Single-byte 8O1 receiver: start, 8 data bits LSB first, odd parity, stop.
// The line must already be synchronised to clock.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   rx             synchronised serial line, idle high
//   habilita       allows a falling edge in IDLE to start a frame
//   desarma        forces the receiver to see the line high before re-arming
//   partida        combinational: a frame starts this cycle
//   byte_dado      last assembled data byte
//   byte_ok        one-cycle pulse, stop bit sampled high
//   erro_par       parity error of the last byte, valid with byte_ok
//   erro_stop      one-cycle pulse, stop bit sampled low
//   falso_inicio   one-cycle pulse, start bit was high again at mid-bit
//   estado         current state code (IDLE..STOP)
module rx_serial_8o1
  import tusca_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx,
  input  logic                       habilita,
  input  logic                       desarma,
  output logic                       partida,
  output logic [FRAME_DATA_BITS-1:0] byte_dado,
  output logic                       byte_ok,
  output logic                       erro_par,
  output logic                       erro_stop,
  output logic                       falso_inicio,
  output estado_t                    estado
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(FRAME_DATA_BITS);
  localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FIM_MEIO = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] ULTIMO   = IDX_W'(FRAME_DATA_BITS - 1);

  estado_t          estado_prox;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             armado;
  logic             fim_meio;
  logic             fim_bit;

  assign fim_meio = (cnt == FIM_MEIO);
  assign fim_bit  = (cnt == FIM_BIT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_prox;
  end

  // Next state and the single-cycle event outputs. A start needs the line to
  // have been seen high since the last abort (armado), so a line stuck low
  // cannot retrigger frames back to back.
  always_comb begin
    estado_prox  = estado;
    partida      = 1'b0;
    byte_ok      = 1'b0;
    erro_stop    = 1'b0;
    falso_inicio = 1'b0;
    case (estado)
      IDLE: begin
        if (habilita && armado && !rx) begin
          partida     = 1'b1;
          estado_prox = START;
        end
      end
      START: begin
        if (fim_meio) begin
          falso_inicio = rx;
          estado_prox  = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (fim_bit && (bit_idx == ULTIMO)) estado_prox = PARITY;
      end
      PARITY: begin
        if (fim_bit) estado_prox = STOP;
      end
      STOP: begin
        if (fim_bit) begin
          byte_ok     = rx;
          erro_stop   = !rx;
          estado_prox = IDLE;
        end
      end
      default: estado_prox = IDLE;
    endcase
  end

  // Bit timing, shift register and parity check. The counter restarts at the
  // middle of the start bit, so every later sample lands mid-bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      byte_dado <= '0;
      erro_par  <= 1'b0;
      armado    <= 1'b0;
    end else begin
      if (rx)                          armado <= 1'b1;
      else if (desarma || erro_stop)   armado <= 1'b0;

      case (estado)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        START: begin
          cnt <= fim_meio ? '0 : cnt + CNT_W'(1);
        end
        DATA: begin
          if (fim_bit) begin
            cnt       <= '0;
            byte_dado <= {rx, byte_dado[FRAME_DATA_BITS-1:1]};
            bit_idx   <= bit_idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (fim_bit) begin
            cnt      <= '0;
            erro_par <= ((^{byte_dado, rx}) != PARIDADE_IMPAR);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          cnt <= fim_bit ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/recepcao_serial_16b.sv
// 16-bit word receiver: two consecutive 8O1 bytes, low byte first, form
// dado = {byte1, byte0}. Byte 1 must start within TIMEOUT_BITS bit-times of
// byte 0, otherwise byte 0 is dropped.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   rx_serial       serial line, idle high (asynchronous to clock)
//   dado            last completed word, held until the next pronto
//   pronto          one-cycle pulse when dado is updated
//   erro_paridade   set when either byte of the word failed odd parity
//   erro_quadro     one-cycle pulse, stop bit low; partial word discarded
//   erro_timeout    one-cycle pulse, byte 1 late; byte 0 discarded
//   db_estado       current state code
module recepcao_serial_16b
  import tusca_serial_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [15:0] dado,
  output logic        pronto,
  output logic        erro_paridade,
  output logic        erro_quadro,
  output logic        erro_timeout,
  output logic [3:0]  db_estado
);

  localparam int CLKS_PER_BIT   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TIMEOUT_CICLOS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W          = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TMO_W-1:0] TMO_FIM = TMO_W'(TIMEOUT_CICLOS - 1);

  logic                       rx_meta;
  logic                       rx_sync;
  fase_t                      fase;
  fase_t                      fase_prox;
  logic                       indice;
  logic [FRAME_DATA_BITS-1:0] byte0;
  logic                       par0;
  logic [TMO_W-1:0]           tmo_cnt;
  logic                       estoura;
  logic                       habilita;

  logic                       partida;
  logic [FRAME_DATA_BITS-1:0] byte_dado;
  logic                       byte_ok;
  logic                       erro_par;
  logic                       erro_stop;
  logic                       falso_inicio;
  estado_t                    estado_rx;

  // Two-flop synchroniser, reset to the idle level so reset release does not
  // look like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // When the timeout expires the receiver is held off in that same cycle, so
  // a coincident falling edge is dropped and desarma makes it wait for high.
  assign estoura  = (fase == FASE_WAIT_B1) && (tmo_cnt == TMO_FIM);
  assign habilita = (fase == FASE_RX) || ((fase == FASE_WAIT_B1) && !estoura);

  rx_serial_8o1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx_sync),
    .habilita     (habilita),
    .desarma      (estoura),
    .partida      (partida),
    .byte_dado    (byte_dado),
    .byte_ok      (byte_ok),
    .erro_par     (erro_par),
    .erro_stop    (erro_stop),
    .falso_inicio (falso_inicio),
    .estado       (estado_rx)
  );

  // Phase register of the word assembler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fase <= FASE_RX;
    else       fase <= fase_prox;
  end

  // Phase transitions. A false start on byte 1 goes back to waiting without
  // restarting the idle count.
  always_comb begin
    fase_prox = fase;
    case (fase)
      FASE_RX: begin
        if (byte_ok)                          fase_prox = FASE_BYTE_DONE;
        else if (falso_inicio && indice)      fase_prox = FASE_WAIT_B1;
      end
      FASE_BYTE_DONE: begin
        fase_prox = indice ? FASE_RX : FASE_WAIT_B1;
      end
      FASE_WAIT_B1: begin
        if (estoura || partida) fase_prox = FASE_RX;
      end
      default: fase_prox = FASE_RX;
    endcase
  end

  // Byte indexing, idle timer, word assembly and the registered pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado          <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_quadro   <= 1'b0;
      erro_timeout  <= 1'b0;
      indice        <= 1'b0;
      byte0         <= '0;
      par0          <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      pronto       <= 1'b0;
      erro_quadro  <= 1'b0;
      erro_timeout <= 1'b0;
      case (fase)
        FASE_RX: begin
          if (erro_stop) begin
            erro_quadro <= 1'b1;
            indice      <= 1'b0;
            par0        <= 1'b0;
          end
        end
        FASE_BYTE_DONE: begin
          if (!indice) begin
            byte0   <= byte_dado;
            par0    <= erro_par;
            indice  <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            dado          <= {byte_dado, byte0};
            pronto        <= 1'b1;
            erro_paridade <= par0 | erro_par;
            indice        <= 1'b0;
            par0          <= 1'b0;
          end
        end
        FASE_WAIT_B1: begin
          if (estoura) begin
            erro_timeout <= 1'b1;
            indice       <= 1'b0;
            par0         <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Debug state code: the receiver's own code while it owns the line.
  always_comb begin
    db_estado = estado_rx;
    if (fase == FASE_BYTE_DONE)    db_estado = BYTE_DONE;
    else if (fase == FASE_WAIT_B1) db_estado = WAIT_B1;
  end

endmodule

// File: tb/tb_recepcao_serial_16b.sv
// Self-checking bench for recepcao_serial_16b.
// Instance A runs the slow channel (200 kHz / 9600 = 20 clocks per bit),
// instance B the fast one (1.5 MHz / 115200 = 13 clocks per bit), both on
// the same simulation clock so a whole run stays short.
module tb_recepcao_serial_16b;

  localparam int CPB_A = 20;
  localparam int CPB_B = 13;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          inv0;
    bit          inv1;
    int          gap;
    bit          esticar;
    logic [15:0] exp_dado;
    logic        exp_par;
  } vetor_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_a  = 1'b1;
  logic        rx_b  = 1'b1;

  logic [15:0] dado_a, dado_b;
  logic        pronto_a, pronto_b;
  logic        par_a, par_b;
  logic        quadro_a, quadro_b;
  logic        tmo_a, tmo_b;
  logic [3:0]  db_a, db_b;

  int vetores = 0;
  int erros   = 0;

  int n_pronto_a = 0, n_quadro_a = 0, n_tmo_a = 0;
  int n_pronto_b = 0, n_quadro_b = 0, n_tmo_b = 0;
  int max_estado_a = 0;
  bit rastreia = 1'b0;
  logic [15:0] palavras_b[$];

  vetor_t tabela[6];
  logic [15:0] rajada[8];

  always #5 clock = ~clock;

  recepcao_serial_16b #(
    .CLK_FREQ(200_000), .BAUD(9600), .TIMEOUT_BITS(20)
  ) dut_a (
    .clock(clock), .reset(reset), .rx_serial(rx_a),
    .dado(dado_a), .pronto(pronto_a), .erro_paridade(par_a),
    .erro_quadro(quadro_a), .erro_timeout(tmo_a), .db_estado(db_a)
  );

  recepcao_serial_16b #(
    .CLK_FREQ(1_500_000), .BAUD(115200), .TIMEOUT_BITS(20)
  ) dut_b (
    .clock(clock), .reset(reset), .rx_serial(rx_b),
    .dado(dado_b), .pronto(pronto_b), .erro_paridade(par_b),
    .erro_quadro(quadro_b), .erro_timeout(tmo_b), .db_estado(db_b)
  );

  // Pulse counters and captured words, sampled on the falling edge.
  always @(negedge clock) begin
    if (pronto_a) n_pronto_a <= n_pronto_a + 1;
    if (quadro_a) n_quadro_a <= n_quadro_a + 1;
    if (tmo_a)    n_tmo_a    <= n_tmo_a + 1;
    if (pronto_b) begin
      n_pronto_b <= n_pronto_b + 1;
      palavras_b.push_back(dado_b);
    end
    if (quadro_b) n_quadro_b <= n_quadro_b + 1;
    if (tmo_b)    n_tmo_b    <= n_tmo_b + 1;
    if (!rastreia)                   max_estado_a <= 0;
    else if (int'(db_a) > max_estado_a) max_estado_a <= int'(db_a);
  end

  task automatic checkOutput(input string nome, input logic [31:0] atual,
                             input logic [31:0] esperado);
    vetores++;
    if (atual !== esperado) begin
      erros++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
    end
  endtask

  // Holds one line at a level for a number of clocks; called on a falling edge.
  task automatic bit_line(input bit sel, input logic v, input int ciclos);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (ciclos) @(negedge clock);
  endtask

  // One 8O1 frame. With esticar, frame bits 0,2,4,6,8 last one extra clock.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit inv_par,
                            input logic stop_val, input bit esticar);
    int   cpb;
    logic p;
    cpb = sel ? CPB_B : CPB_A;
    p   = (~^d) ^ inv_par;
    bit_line(sel, 1'b0, cpb + int'(esticar));
    for (int i = 0; i < 8; i++)
      bit_line(sel, d[i], cpb + ((esticar && (i % 2 == 1)) ? 1 : 0));
    bit_line(sel, p, cpb);
    bit_line(sel, stop_val, cpb);
    if (sel) rx_b = 1'b1;
    else     rx_a = 1'b1;
  endtask

  // Sends one word on channel A and checks the delivered result.
  task automatic applyStimulus(input vetor_t v, input string nome);
    int bp, bq, bt, ciclos;
    bp = n_pronto_a; bq = n_quadro_a; bt = n_tmo_a; ciclos = 0;
    send_frame(1'b0, v.b0, v.inv0, 1'b1, v.esticar);
    repeat (v.gap * CPB_A) @(negedge clock);
    send_frame(1'b0, v.b1, v.inv1, 1'b1, v.esticar);
    repeat (CPB_A) @(negedge clock);
    while (n_pronto_a == bp && ciclos < 200) begin
      @(negedge clock);
      ciclos++;
    end
    repeat (4) @(negedge clock);
    checkOutput({nome, " pronto count"}, n_pronto_a - bp, 1);
    checkOutput({nome, " dado"}, dado_a, v.exp_dado);
    checkOutput({nome, " erro_paridade"}, par_a, v.exp_par);
    checkOutput({nome, " erro_quadro count"}, n_quadro_a - bq, 0);
    checkOutput({nome, " erro_timeout count"}, n_tmo_a - bt, 0);
  endtask

  initial begin
    vetor_t v;
    int bp, bq, bt, base_b, ciclos;

    tabela[0] = '{8'h02, 8'h22, 1'b0, 1'b0, 1,  1'b0, 16'h2202, 1'b0};
    tabela[1] = '{8'h34, 8'h12, 1'b1, 1'b1, 1,  1'b0, 16'h1234, 1'b1};
    tabela[2] = '{8'h02, 8'h22, 1'b0, 1'b0, 1,  1'b0, 16'h2202, 1'b0};
    tabela[3] = '{8'hA5, 8'h5A, 1'b0, 1'b1, 1,  1'b1, 16'h5AA5, 1'b1};
    tabela[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 18, 1'b0, 16'h00FF, 1'b1};
    tabela[5] = '{8'h00, 8'h80, 1'b0, 1'b0, 3,  1'b1, 16'h8000, 1'b0};

    rajada[0] = 16'h1000; rajada[1] = 16'h2001; rajada[2] = 16'h3002;
    rajada[3] = 16'h4003; rajada[4] = 16'h5004; rajada[5] = 16'h6005;
    rajada[6] = 16'h7008; rajada[7] = 16'h1111;

    // Reset values, then release without any pulse.
    repeat (3) @(negedge clock);
    checkOutput("reset dado", dado_a, 16'h0000);
    checkOutput("reset pronto", pronto_a, 1'b0);
    checkOutput("reset erro_paridade", par_a, 1'b0);
    checkOutput("reset erro_quadro", quadro_a, 1'b0);
    checkOutput("reset erro_timeout", tmo_a, 1'b0);
    checkOutput("reset db_estado", db_a, 4'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("release pulses", n_pronto_a + n_quadro_a + n_tmo_a, 0);

    // Table-driven words on the slow channel.
    for (int i = 0; i < 6; i++)
      applyStimulus(tabela[i], $sformatf("v%0d", i));

    // Short glitch: START is entered, nothing beyond it, no pulses.
    bp = n_pronto_a; bq = n_quadro_a; bt = n_tmo_a;
    rastreia = 1'b1;
    @(negedge clock);
    bit_line(1'b0, 1'b0, 5);
    bit_line(1'b0, 1'b1, 3 * CPB_A);
    checkOutput("glitch max db_estado", max_estado_a, 1);
    rastreia = 1'b0;
    checkOutput("glitch db_estado", db_a, 4'd0);
    checkOutput("glitch pulses", (n_pronto_a - bp) + (n_quadro_a - bq) + (n_tmo_a - bt), 0);
    checkOutput("glitch dado held", dado_a, 16'h8000);

    // Lone byte 0 followed by 25 idle bit-times: one timeout.
    bp = n_pronto_a; bt = n_tmo_a;
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (25 * CPB_A) @(negedge clock);
    checkOutput("timeout count", n_tmo_a - bt, 1);
    checkOutput("timeout pronto count", n_pronto_a - bp, 0);
    checkOutput("timeout db_estado", db_a, 4'd0);
    v = '{8'h00, 8'h10, 1'b0, 1'b0, 1, 1'b0, 16'h1000, 1'b0};
    applyStimulus(v, "after timeout");

    // Stop bit low on byte 0.
    bp = n_pronto_a; bq = n_quadro_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3 * CPB_A) @(negedge clock);
    checkOutput("framing quadro count", n_quadro_a - bq, 1);
    checkOutput("framing pronto count", n_pronto_a - bp, 0);
    checkOutput("framing dado held", dado_a, 16'h1000);

    // Line stuck low for 40 bit-times: exactly one framing error.
    bp = n_pronto_a; bq = n_quadro_a; bt = n_tmo_a;
    bit_line(1'b0, 1'b0, 40 * CPB_A);
    bit_line(1'b0, 1'b1, 3 * CPB_A);
    checkOutput("stuck low quadro count", n_quadro_a - bq, 1);
    checkOutput("stuck low other pulses", (n_pronto_a - bp) + (n_tmo_a - bt), 0);
    v = '{8'h02, 8'h30, 1'b0, 1'b0, 1, 1'b0, 16'h3002, 1'b0};
    applyStimulus(v, "after framing");

    // Reset during the data bits of byte 1 of 0x4003.
    bp = n_pronto_a;
    send_frame(1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
    bit_line(1'b0, 1'b1, CPB_A);
    bit_line(1'b0, 1'b0, CPB_A);
    bit_line(1'b0, 1'b0, CPB_A);
    bit_line(1'b0, 1'b0, CPB_A);
    bit_line(1'b0, 1'b0, CPB_A);
    checkOutput("pre-reset db_estado", db_a, 4'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid reset dado", dado_a, 16'h0000);
    checkOutput("mid reset pronto", pronto_a, 1'b0);
    checkOutput("mid reset erro_paridade", par_a, 1'b0);
    checkOutput("mid reset errors", {quadro_a, tmo_a}, 2'b00);
    checkOutput("mid reset db_estado", db_a, 4'd0);
    rx_a = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5 * CPB_A) @(negedge clock);
    checkOutput("post reset pronto count", n_pronto_a - bp, 0);
    v = '{8'h04, 8'h50, 1'b0, 1'b0, 1, 1'b0, 16'h5004, 1'b0};
    applyStimulus(v, "after reset");

    // Fast channel: eight words back to back, one idle bit between frames.
    base_b = palavras_b.size();
    bq = n_quadro_b; bt = n_tmo_b;
    for (int i = 0; i < 8; i++) begin
      send_frame(1'b1, rajada[i][7:0], 1'b0, 1'b1, 1'b0);
      bit_line(1'b1, 1'b1, CPB_B);
      send_frame(1'b1, rajada[i][15:8], 1'b0, 1'b1, 1'b0);
      bit_line(1'b1, 1'b1, CPB_B);
    end
    ciclos = 0;
    while (palavras_b.size() < base_b + 8 && ciclos < 100) begin
      @(negedge clock);
      ciclos++;
    end
    repeat (4) @(negedge clock);
    checkOutput("burst word count", palavras_b.size() - base_b, 8);
    for (int i = 0; i < 8; i++) begin
      if (base_b + i < palavras_b.size())
        checkOutput($sformatf("burst word %0d", i), palavras_b[base_b + i], rajada[i]);
      else
        checkOutput($sformatf("burst word %0d missing", i), 32'hFFFF_FFFF, rajada[i]);
    end
    checkOutput("burst erro_paridade", par_b, 1'b0);
    checkOutput("burst error pulses", (n_quadro_b - bq) + (n_tmo_b - bt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
